sine_dds: RTL and testbench



---
 rtl/sine_dds_pkg.sv | 33 +++
 rtl/sine_dds_if.sv | 32 +++
 rtl/sine_quarter_rom.sv | 36 +++
 rtl/sine_dds.sv | 157 +++++++++++++++
 tb/tb_sine_dds.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/sine_dds_pkg.sv
// Shared types and elaboration-time helpers for the sine_dds DDS source.
// Used by every sine_dds file; no configuration macros are read here.
package sine_dds_pkg;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;

    localparam int unsigned FRAC_W = 28;
    localparam longint PI_FX = 64'sd843314857;

    // Quarter-wave entry k of n: AMP*sin(pi/2*k/n), evaluated with a fixed-point
    // Taylor series and truncated toward zero; the end points are exact.
    function automatic int quarter_entry(int amp, int n, int k);
        longint x, term, sum;
        if (k <= 0) return 0;
        if (k >= n) return amp;
        x = (PI_FX * longint'(k)) / longint'(2 * n);
        term = x;
        sum = x;
        for (int i = 1; i <= 8; i++) begin
            term = (term * x) / (longint'(1) <<< FRAC_W);
            term = (term * x) / (longint'(1) <<< FRAC_W);
            term = -term / longint'((2 * i) * (2 * i + 1));
            sum = sum + term;
        end
        return int'((longint'(amp) * sum) >>> FRAC_W);
    endfunction

    function automatic bit params_ok(int amp, int offset, int data_w);
        return (amp >= 0) && (amp <= offset) &&
               (longint'(offset) + longint'(amp) <= (longint'(1) <<< data_w) - 1);
    endfunction

endpackage

// File: rtl/sine_dds_if.sv
// Control and sample-stream bundle for sine_dds.
// SINE_DDS_COS_EN adds the out_cos sample alongside out_sin.
interface sine_dds_if #(
    parameter int PHASE_W = 16,
    parameter int DATA_W  = 8
);
    logic               en;
    logic               phase_clr;
    logic [PHASE_W-1:0] ftw;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_sin;
`ifdef SINE_DDS_COS_EN
    logic [DATA_W-1:0]  out_cos;
`endif

    modport master (
        output en, phase_clr, ftw, out_ready,
        input  out_valid, out_sin
`ifdef SINE_DDS_COS_EN
        , input out_cos
`endif
    );

    modport slave (
        input  en, phase_clr, ftw, out_ready,
        output out_valid, out_sin
`ifdef SINE_DDS_COS_EN
        , output out_cos
`endif
    );
endinterface

// File: rtl/sine_quarter_rom.sv
// Registered quarter-wave table of N+1 entries with one read port,
// or two when SINE_DDS_COS_EN is defined.
module sine_quarter_rom
    import sine_dds_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int AMP    = 100
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W-2:0] addr_a,
    output logic [DATA_W-1:0] data_a
`ifdef SINE_DDS_COS_EN
    ,
    input  logic [ADDR_W-2:0] addr_b,
    output logic [DATA_W-1:0] data_b
`endif
);
    localparam int N = 1 << (ADDR_W - 2);

    logic [DATA_W-1:0] rom [N+1];

    for (genvar k = 0; k <= N; k++) begin : g_rom
        assign rom[k] = DATA_W'(quarter_entry(AMP, N, k));
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data_a <= rom[addr_a];
`ifdef SINE_DDS_COS_EN
            data_b <= rom[addr_b];
`endif
        end
    end
endmodule

// File: rtl/sine_dds.sv
// Phase-accumulator sine source with quarter-wave folding and valid/ready output.
// Define SINE_DDS_COS_EN to add the aligned out_cos channel.
module sine_dds
    import sine_dds_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int AMP     = 100,
    parameter int OFFSET  = 100
) (
    input logic        clk,
    input logic        rst_n,
    sine_dds_if.slave  bus
);
    localparam int N  = 1 << (ADDR_W - 2);
    localparam int IW = ADDR_W - 2;
    localparam int AW = ADDR_W - 1;

    if (!params_ok(AMP, OFFSET, DATA_W)) begin : g_bad_range
        $error("sine_dds: AMP/OFFSET do not fit the DATA_W output range");
    end
    if (ADDR_W < 3 || ADDR_W > PHASE_W) begin : g_bad_addr
        $error("sine_dds: ADDR_W must lie in 3..PHASE_W");
    end

    function automatic logic [AW-1:0] fold_addr(quad_e quad, logic [IW-1:0] q);
        logic [1:0] qb;
        qb = quad;
        return qb[0] ? AW'(N) - AW'(q) : AW'(q);
    endfunction

    function automatic logic [DATA_W-1:0] sat_u(logic signed [DATA_W:0] v);
        if (v < 0) return '0;
        if (v > $signed({1'b0, {DATA_W{1'b1}}})) return '1;
        return v[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(quad_e quad, logic [DATA_W-1:0] mag);
        logic [1:0]            qb;
        logic signed [DATA_W:0] off;
        logic signed [DATA_W:0] m;
        qb  = quad;
        off = $signed((DATA_W + 1)'(OFFSET));
        m   = $signed({1'b0, mag});
        return sat_u(qb[1] ? off - m : off + m);
    endfunction

    logic [PHASE_W-1:0] acc;
    logic               vld_p0, vld_p1, vld_p2, vld_p3;
    logic               adv, issue;

    logic [ADDR_W-1:0]  phase_p0;
    logic [1:0]         quad_raw;
    logic [IW-1:0]      idx_raw;
    quad_e              quad_s_p1, quad_s_p2;
    logic [AW-1:0]      addr_s_p1;
    logic [DATA_W-1:0]  mag_s_p2;
    logic [DATA_W-1:0]  sin_p3;

    assign adv   = !vld_p3 || bus.out_ready;
    assign issue = bus.en && adv && !bus.phase_clr;

    // Control: accumulator and stage valids; phase_clr flushes even while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (bus.phase_clr) begin
            acc    <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            if (adv) begin
                vld_p0 <= issue;
                vld_p1 <= vld_p0;
                vld_p2 <= vld_p1;
                vld_p3 <= vld_p2;
            end
            if (issue) acc <= acc + bus.ftw;
        end
    end

    assign quad_raw = phase_p0[ADDR_W-1 -: 2];
    assign idx_raw  = phase_p0[IW-1:0];

    // p0: captured phase; p1: folded quadrant and table address.
    always_ff @(posedge clk) begin
        if (adv) begin
            phase_p0  <= acc[PHASE_W-1 -: ADDR_W];
            quad_s_p1 <= quad_e'(quad_raw);
            addr_s_p1 <= fold_addr(quad_e'(quad_raw), idx_raw);
            quad_s_p2 <= quad_s_p1;
        end
    end

`ifdef SINE_DDS_COS_EN
    quad_e             quad_c_p1, quad_c_p2;
    logic [AW-1:0]     addr_c_p1;
    logic [DATA_W-1:0] mag_c_p2;
    logic [DATA_W-1:0] cos_p3;

    // Cosine is the same phase advanced by one quadrant.
    always_ff @(posedge clk) begin
        if (adv) begin
            quad_c_p1 <= quad_e'(quad_raw + 2'd1);
            addr_c_p1 <= fold_addr(quad_e'(quad_raw + 2'd1), idx_raw);
            quad_c_p2 <= quad_c_p1;
        end
    end
`endif

    // p2: registered table read.
    sine_quarter_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .AMP    (AMP)
    ) u_rom (
        .clk    (clk),
        .en     (adv),
        .addr_a (addr_s_p1),
        .data_a (mag_s_p2)
`ifdef SINE_DDS_COS_EN
        ,
        .addr_b (addr_c_p1),
        .data_b (mag_c_p2)
`endif
    );

    // p3: sign and offset; only real samples load so the output holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_p3 <= DATA_W'(OFFSET);
        end else if (adv && vld_p2) begin
            sin_p3 <= apply_sign(quad_s_p2, mag_s_p2);
        end
    end

`ifdef SINE_DDS_COS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cos_p3 <= DATA_W'(OFFSET);
        end else if (adv && vld_p2) begin
            cos_p3 <= apply_sign(quad_c_p2, mag_c_p2);
        end
    end
    assign bus.out_cos = cos_p3;
`endif

    assign bus.out_valid = vld_p3;
    assign bus.out_sin   = sin_p3;
endmodule

// File: tb/tb_sine_dds.sv
// Directed bench for sine_dds with a pipeline model and an expected-sample queue.
// Define SINE_DDS_COS_EN to also check the cosine channel.
module tb_sine_dds;
    localparam int PHASE_W = 16;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;

    typedef struct {
        logic [7:0] s;
        logic [7:0] c;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    exp_t        sb[$];
    int          gold_q[$];
    logic        m_vld[4];
    logic [15:0] m_acc;
    bit          record;
    logic [7:0]  sin_h[$];
    logic [7:0]  cos_h[$];

    sine_dds_if #(.PHASE_W(PHASE_W), .DATA_W(DATA_W)) bus ();

    sine_dds #(
        .PHASE_W (PHASE_W),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .AMP     (100),
        .OFFSET  (100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_sample(logic [15:0] p);
        int  quad, q, idx, mag;
        real a;
        quad = int'(p[15:14]);
        q    = int'(p[13:11]);
        idx  = (quad % 2 == 1) ? 8 - q : q;
        a    = 100.0 * $sin(3.141592653589793 / 2.0 * real'(idx) / 8.0);
        mag  = int'($floor(a + 1.0e-9));
        return (quad >= 2) ? 8'(100 - mag) : 8'(100 + mag);
    endfunction

    task automatic model_reset();
        m_acc = '0;
        for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
        sb.delete();
    endtask

    task automatic tick();
        exp_t e;
        int   g;
        bit   adv;
        n_cmp++;
        assert (bus.out_valid === m_vld[3])
        else begin
            n_err++;
            $error("FAIL out_valid observed=%0b expected=%0b", bus.out_valid, m_vld[3]);
        end
        if (m_vld[3] && sb.size() > 0) begin
            e = sb[0];
            n_cmp++;
            assert (bus.out_sin === e.s)
            else begin
                n_err++;
                $error("FAIL out_sin observed=%0d expected=%0d", bus.out_sin, e.s);
            end
`ifdef SINE_DDS_COS_EN
            n_cmp++;
            assert (bus.out_cos === e.c)
            else begin
                n_err++;
                $error("FAIL out_cos observed=%0d expected=%0d", bus.out_cos, e.c);
            end
`endif
            if (bus.out_ready) begin
                void'(sb.pop_front());
                if (gold_q.size() > 0) begin
                    g = gold_q.pop_front();
                    if (g >= 0) begin
                        n_cmp++;
                        assert (bus.out_sin === 8'(g))
                        else begin
                            n_err++;
                            $error("FAIL golden_sin observed=%0d expected=%0d", bus.out_sin, g);
                        end
                    end
                end
`ifdef SINE_DDS_COS_EN
                if (record) begin
                    sin_h.push_back(bus.out_sin);
                    cos_h.push_back(bus.out_cos);
                end
`endif
            end
        end
        adv = !m_vld[3] || bus.out_ready;
        if (bus.phase_clr) begin
            model_reset();
        end else if (adv) begin
            m_vld[3] = m_vld[2];
            m_vld[2] = m_vld[1];
            m_vld[1] = m_vld[0];
            m_vld[0] = bus.en;
            if (bus.en) begin
                e.s = ref_sample(m_acc);
                e.c = ref_sample(m_acc + 16'h4000);
                sb.push_back(e);
                m_acc = m_acc + bus.ftw;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        record = 1'b0;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.phase_clr = 1'b0;
        bus.ftw = 16'd2048;
        bus.out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);

        n_cmp++;
        assert (bus.out_valid === 1'b0)
        else begin n_err++; $error("FAIL reset_valid observed=%0b expected=0", bus.out_valid); end
        n_cmp++;
        assert (bus.out_sin === 8'd100)
        else begin n_err++; $error("FAIL reset_sin observed=%0d expected=100", bus.out_sin); end
        rst_n = 1'b1;

        // Free-running ftw=2048 with golden samples
        foreach (gold_q[i]) ;
        gold_q = '{100, 119, 138, 155, 170, 183, 192, 198, 200, 198, 192,
                   -1, -1, -1, -1, -1, 100, 81, 62};
        bus.en = 1'b1;
        ticks(25);

        // Back-pressure for 5 cycles, then release
        bus.out_ready = 1'b0;
        ticks(5);
        bus.out_ready = 1'b1;
        ticks(10);

        // phase_clr while stalled, then restart from phase 0
        bus.out_ready = 1'b0;
        ticks(2);
        bus.phase_clr = 1'b1;
        tick();
        bus.phase_clr = 1'b0;
        bus.out_ready = 1'b1;
        gold_q.push_back(100);
        ticks(4);
        bus.en = 1'b0;
        ticks(5);

        // Wrap with ftw=0xFFFF
        bus.phase_clr = 1'b1;
        tick();
        bus.phase_clr = 1'b0;
        bus.ftw = 16'hFFFF;
        bus.en = 1'b1;
        gold_q.push_back(100);
        gold_q.push_back(81);
        gold_q.push_back(81);
        gold_q.push_back(81);
        ticks(4);
        bus.en = 1'b0;
        ticks(6);

        // Asynchronous reset mid-stream
        bus.ftw = 16'd2048;
        bus.en = 1'b1;
        ticks(6);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        assert (bus.out_valid === 1'b0)
        else begin n_err++; $error("FAIL async_rst_valid observed=%0b expected=0", bus.out_valid); end
        n_cmp++;
        assert (bus.out_sin === 8'd100)
        else begin n_err++; $error("FAIL async_rst_sin observed=%0d expected=100", bus.out_sin); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        gold_q.push_back(100);
        ticks(8);

`ifdef SINE_DDS_COS_EN
        bus.phase_clr = 1'b1;
        tick();
        bus.phase_clr = 1'b0;
        sin_h.delete();
        cos_h.delete();
        record = 1'b1;
        ticks(40);
        record = 1'b0;
        n_cmp++;
        assert (cos_h.size() > 0 && cos_h[0] === 8'd200)
        else begin n_err++; $error("FAIL first_cos observed=%0d expected=200", cos_h.size() > 0 ? cos_h[0] : 8'd0); end
        for (int n = 0; n + 8 < sin_h.size(); n++) begin
            n_cmp++;
            assert (cos_h[n] === sin_h[n+8])
            else begin n_err++; $error("FAIL cos_lead observed=%0d expected=%0d", cos_h[n], sin_h[n+8]); end
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
